// File: rtl/sfft_pkg.sv
// sfft_pkg: shared types, widths and helpers for the SFFT buffer reader
package sfft_pkg;

    localparam int SFFT_ADDR_W   = 4;
    localparam int SFFT_DATA_W   = 16;
    localparam int SFFT_NUM_BINS = 8;
    localparam int FIFO_DEPTH    = 4;

    typedef struct packed {
        logic signed [SFFT_DATA_W-1:0] re;
        logic signed [SFFT_DATA_W-1:0] im;
    } complex_t;

    typedef struct packed {
        logic [SFFT_ADDR_W-2:0] idx;
        complex_t               a;
        complex_t               b;
    } bin_pair_t;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN,
        DONE
    } reader_state_e;

    // Absolute value as an unsigned word; the most negative input maps to 2^(W-1)
    function automatic logic [SFFT_DATA_W-1:0] uabs(logic [SFFT_DATA_W-1:0] x);
        return x[SFFT_DATA_W-1] ? -x : x;
    endfunction

    // |re| + |im| widened by one bit so the sum can never wrap
    function automatic logic [SFFT_DATA_W:0] cmag(complex_t c);
        return {1'b0, uabs(c.re)} + {1'b0, uabs(c.im)};
    endfunction

endpackage

// File: rtl/sfft_reader_fifo.sv
// sfft_reader_fifo: small synchronous FIFO of bin pairs with occupancy count
module sfft_reader_fifo
    import sfft_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic                       pop,
    input  bin_pair_t                  wdata,
    output bin_pair_t                  rdata,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    bin_pair_t         mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;

    assign rdata = mem[rd_ptr];

    // Storage, wrapping pointers and occupancy; the caller guarantees no overflow/underflow
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= (wr_ptr == PW'(DEPTH-1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= (rd_ptr == PW'(DEPTH-1)) ? '0 : rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

endmodule

// File: rtl/sfft_buffer_reader.sv
// sfft_buffer_reader: sweeps the Real/Imag buffer two bins per cycle and streams pairs
// over valid/ready. Optional SFFT_READER_MAG_EN adds |re|+|im| outputs per bin.
module sfft_buffer_reader #(
    parameter int ADDR_W     = sfft_pkg::SFFT_ADDR_W,
    parameter int DATA_W     = sfft_pkg::SFFT_DATA_W,
    parameter int NUM_BINS   = sfft_pkg::SFFT_NUM_BINS,
    parameter int FIFO_DEPTH = sfft_pkg::FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] ramAddress_A,
    output logic [ADDR_W-1:0] ramAddress_B,
    output logic              ramWriteEnable_A,
    output logic              ramWriteEnable_B,
    input  logic [DATA_W-1:0] ramDataReal_A,
    input  logic [DATA_W-1:0] ramDataReal_B,
    input  logic [DATA_W-1:0] ramDataImag_A,
    input  logic [DATA_W-1:0] ramDataImag_B,
    output logic              outValid,
    input  logic              outReady,
    output logic [ADDR_W-2:0] outPairIndex,
    output logic [DATA_W-1:0] outReal_A,
    output logic [DATA_W-1:0] outReal_B,
    output logic [DATA_W-1:0] outImag_A,
    output logic [DATA_W-1:0] outImag_B,
    output logic              outLast
`ifdef SFFT_READER_MAG_EN
    ,
    output logic [DATA_W:0]   outMag_A,
    output logic [DATA_W:0]   outMag_B
`endif
);

    import sfft_pkg::*;

    localparam int                NUM_PAIRS = NUM_BINS / 2;
    localparam int                CW        = $clog2(FIFO_DEPTH + 1);
    localparam logic [ADDR_W-2:0] LAST_IDX  = (ADDR_W-1)'(NUM_PAIRS - 1);

    reader_state_e     state;
    reader_state_e     state_nxt;
    logic [ADDR_W-2:0] pair_cnt;
    logic [ADDR_W-2:0] idx1;
    logic [ADDR_W-2:0] idx2;
    logic              v1;
    logic              v2;
    logic              issue;
    logic              fire;
    logic [CW-1:0]     count;
    bin_pair_t         head;
    bin_pair_t         wdata;

    // A pair may be issued only if the FIFO has room for it after everything already in flight lands
    assign issue = (state == READ) &&
                   ((CW+2)'(FIFO_DEPTH) > (CW+2)'(count) + (CW+2)'(v1) + (CW+2)'(v2));
    assign fire  = outValid && outReady;
    assign wdata = {idx2, ramDataReal_A, ramDataImag_A, ramDataReal_B, ramDataImag_B};

    assign busy             = (state != IDLE);
    assign done             = (state == DONE);
    assign ramWriteEnable_A = 1'b0;
    assign ramWriteEnable_B = 1'b0;
    assign outValid         = (count != '0);
    assign outPairIndex     = head.idx;
    assign outReal_A        = head.a.re;
    assign outImag_A        = head.a.im;
    assign outReal_B        = head.b.re;
    assign outImag_B        = head.b.im;
    assign outLast          = outValid && (head.idx == LAST_IDX);
`ifdef SFFT_READER_MAG_EN
    assign outMag_A         = cmag(head.a);
    assign outMag_B         = cmag(head.b);
`endif

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next state: issue all pairs, wait for the last beat to leave, pulse done for one cycle
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = start ? READ : IDLE;
            READ:    state_nxt = (issue && pair_cnt == LAST_IDX) ? DRAIN : READ;
            DRAIN:   state_nxt = (fire && outLast) ? DONE : DRAIN;
            default: state_nxt = IDLE;
        endcase
    end

    // Address issue plus a two-stage tag pipeline matching the buffer's registered read
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pair_cnt     <= '0;
            ramAddress_A <= '0;
            ramAddress_B <= '0;
            v1           <= 1'b0;
            v2           <= 1'b0;
            idx1         <= '0;
            idx2         <= '0;
        end else begin
            if (issue) begin
                ramAddress_A <= {pair_cnt, 1'b0};
                ramAddress_B <= {pair_cnt, 1'b1};
                pair_cnt     <= pair_cnt + 1'b1;
            end
            if (state == DONE) pair_cnt <= '0;
            v1   <= issue;
            idx1 <= pair_cnt;
            v2   <= v1;
            idx2 <= idx1;
        end
    end

    sfft_reader_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (v2),
        .pop     (fire),
        .wdata   (wdata),
        .rdata   (head),
        .count   (count)
    );

endmodule

// File: tb/tb_sfft_buffer_reader.sv
// tb_sfft_buffer_reader: scoreboard bench for the SFFT buffer reader
module tb_sfft_buffer_reader;

    localparam int AW = 4;
    localparam int DW = 16;
    localparam int NP = 4;

    typedef struct {
        int idx;
        int ra;
        int ia;
        int rb;
        int ib;
        int ma;
        int mb;
        int last;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 reset_n = 1'b0;
    logic                 start = 1'b0;
    logic                 outReady = 1'b1;
    logic                 busy;
    logic                 done;
    logic [AW-1:0]        ramAddress_A;
    logic [AW-1:0]        ramAddress_B;
    logic                 ramWriteEnable_A;
    logic                 ramWriteEnable_B;
    logic signed [DW-1:0] ramDataReal_A;
    logic signed [DW-1:0] ramDataReal_B;
    logic signed [DW-1:0] ramDataImag_A;
    logic signed [DW-1:0] ramDataImag_B;
    logic                 outValid;
    logic [AW-2:0]        outPairIndex;
    logic signed [DW-1:0] outReal_A;
    logic signed [DW-1:0] outReal_B;
    logic signed [DW-1:0] outImag_A;
    logic signed [DW-1:0] outImag_B;
    logic                 outLast;
`ifdef SFFT_READER_MAG_EN
    logic [DW:0]          outMag_A;
    logic [DW:0]          outMag_B;
`endif

    int   mem_re [16];
    int   mem_im [16];
    exp_t sbq [$];
    int   nchk = 0;
    int   nfail = 0;
    int   done_cnt = 0;
    int   beats = 0;

    sfft_buffer_reader dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .start            (start),
        .busy             (busy),
        .done             (done),
        .ramAddress_A     (ramAddress_A),
        .ramAddress_B     (ramAddress_B),
        .ramWriteEnable_A (ramWriteEnable_A),
        .ramWriteEnable_B (ramWriteEnable_B),
        .ramDataReal_A    (ramDataReal_A),
        .ramDataReal_B    (ramDataReal_B),
        .ramDataImag_A    (ramDataImag_A),
        .ramDataImag_B    (ramDataImag_B),
        .outValid         (outValid),
        .outReady         (outReady),
        .outPairIndex     (outPairIndex),
        .outReal_A        (outReal_A),
        .outReal_B        (outReal_B),
        .outImag_A        (outImag_A),
        .outImag_B        (outImag_B),
        .outLast          (outLast)
`ifdef SFFT_READER_MAG_EN
        ,
        .outMag_A         (outMag_A),
        .outMag_B         (outMag_B)
`endif
    );

    always #5 clk = ~clk;

    // Buffer model with a one-cycle registered read
    always @(posedge clk) begin
        ramDataReal_A <= DW'(mem_re[ramAddress_A]);
        ramDataImag_A <= DW'(mem_im[ramAddress_A]);
        ramDataReal_B <= DW'(mem_re[ramAddress_B]);
        ramDataImag_B <= DW'(mem_im[ramAddress_B]);
    end

    task automatic check(input string tag, input int got, input int exp);
        nchk++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int iabs(input int x);
        return x < 0 ? -x : x;
    endfunction

    task automatic push_frame();
        exp_t e;
        for (int p = 0; p < NP; p++) begin
            e.idx  = p;
            e.ra   = mem_re[2*p];
            e.ia   = mem_im[2*p];
            e.rb   = mem_re[2*p+1];
            e.ib   = mem_im[2*p+1];
            e.ma   = iabs(e.ra) + iabs(e.ia);
            e.mb   = iabs(e.rb) + iabs(e.ib);
            e.last = (p == NP - 1);
            sbq.push_back(e);
        end
    endtask

    // Output monitor: pops the scoreboard on each handshake and checks stall stability
    initial begin
        exp_t e;
        bit   stall = 0;
        int   p_idx, p_ra, p_ib;
        forever begin
            @(negedge clk);
            #1;
            if (!reset_n) begin
                stall = 0;
            end else begin
                if (stall) begin
                    check("hold_valid", int'(outValid), 1);
                    check("hold_idx", int'(outPairIndex), p_idx);
                    check("hold_re_a", int'(outReal_A), p_ra);
                    check("hold_im_b", int'(outImag_B), p_ib);
                end
                if (done) done_cnt++;
                if (outValid && outReady) begin
                    if (sbq.size() == 0) begin
                        check("extra_beat", int'(outPairIndex), -1);
                    end else begin
                        e = sbq.pop_front();
                        check("idx", int'(outPairIndex), e.idx);
                        check("re_a", int'(outReal_A), e.ra);
                        check("im_a", int'(outImag_A), e.ia);
                        check("re_b", int'(outReal_B), e.rb);
                        check("im_b", int'(outImag_B), e.ib);
                        check("last", int'(outLast), e.last);
`ifdef SFFT_READER_MAG_EN
                        check("mag_a", int'(outMag_A), e.ma);
                        check("mag_b", int'(outMag_B), e.mb);
`endif
                        beats++;
                    end
                end
                stall = outValid && !outReady;
                p_idx = int'(outPairIndex);
                p_ra  = int'(outReal_A);
                p_ib  = int'(outImag_B);
            end
        end
    end

    task automatic run_frame(input bit rnd, input bit poke);
        bit seen = 0;
        int d0 = done_cnt;
        push_frame();
        @(negedge clk);
        start = 1'b1;
        for (int n = 0; n < 300 && !seen; n++) begin
            @(negedge clk);
            start    = poke && (n == 2);
            outReady = rnd ? 1'($urandom_range(1)) : 1'b1;
            if (done) begin
                seen = 1;
                if (poke) start = 1'b1;
            end
        end
        check("frame_done", int'(seen), 1);
        @(negedge clk);
        start    = 1'b0;
        outReady = 1'b1;
        repeat (4) @(negedge clk);
        check("idle_busy", int'(busy), 0);
        check("sb_empty", sbq.size(), 0);
        check("done_pulses", done_cnt - d0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int d0;
        bit ok;
        for (int k = 0; k < 16; k++) begin
            mem_re[k] = k;
            mem_im[k] = -k;
        end
        repeat (3) @(negedge clk);
        check("rst_valid", int'(outValid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_last", int'(outLast), 0);
        check("rst_addr_a", int'(ramAddress_A), 0);
        check("rst_addr_b", int'(ramAddress_B), 0);
        check("rst_re_a", int'(outReal_A), 0);
        check("rst_we", int'({ramWriteEnable_A, ramWriteEnable_B}), 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Exact latency with outReady held high
        push_frame();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("t_busy", int'(busy), 1);
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            check($sformatf("t_valid%0d", i), int'(outValid), int'(i >= 3 && i <= 6));
            check($sformatf("t_last%0d", i), int'(outLast), int'(i == 6));
            check($sformatf("t_done%0d", i), int'(done), int'(i == 7));
        end
        repeat (2) @(negedge clk);
        check("t_idle", int'(busy), 0);
        check("t_sb_empty", sbq.size(), 0);

        // Random backpressure
        for (int r = 0; r < 4; r++) run_frame(1'b1, 1'b0);

        // Start pulses in READ and DONE are ignored, then a clean new frame
        run_frame(1'b0, 1'b1);
        run_frame(1'b0, 1'b0);

        // Reset in the middle of a frame
        d0 = done_cnt;
        beats = 0;
        push_frame();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ok = 0;
        for (int n = 0; n < 50 && !ok; n++) begin
            if (beats >= 2) ok = 1;
            else @(negedge clk);
        end
        check("mid_reached", int'(ok), 1);
        reset_n = 1'b0;
        #1;
        check("mid_valid", int'(outValid), 0);
        check("mid_busy", int'(busy), 0);
        sbq.delete();
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        check("mid_no_done", done_cnt - d0, 0);
        run_frame(1'b0, 1'b0);

`ifdef SFFT_READER_MAG_EN
        mem_re[0] = -(1 << (DW - 1));
        mem_im[0] = 3;
        mem_re[5] = (1 << (DW - 1)) - 1;
        mem_im[5] = -(1 << (DW - 1));
        run_frame(1'b0, 1'b0);
        mem_re[0] = 0;
        mem_im[0] = 0;
        mem_re[5] = 5;
        mem_im[5] = -5;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
        $finish;
    end

endmodule
